// File: rtl/dram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of a single DRAM wrapper port.
// Round-robin on ties, non-preemptive grants, ack watchdog with DRAIN recovery.
module dram_wb_arbiter #(
    parameter int WORD_SIZE      = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  initialized_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WORD_SIZE-1:0]  m0_data_i,
    output logic [WORD_SIZE-1:0]  m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WORD_SIZE-1:0]  m1_data_i,
    output logic [WORD_SIZE-1:0]  m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [WORD_SIZE-1:0]  s_data_o,
    input  logic [WORD_SIZE-1:0]  s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic [15:0] wdog;
    logic [1:0]  grant_q;
    logic [1:0]  err_q;

    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [WORD_SIZE-1:0]  own_data;
    logic                  busy;
    logic                  pick;

    assign own_cyc  = owner ? m1_cyc_i  : m0_cyc_i;
    assign own_stb  = owner ? m1_stb_i  : m0_stb_i;
    assign own_we   = owner ? m1_we_i   : m0_we_i;
    assign own_addr = owner ? m1_addr_i : m0_addr_i;
    assign own_data = owner ? m1_data_i : m0_data_i;

    // Reset gates the outputs so a pending transaction vanishes immediately.
    assign busy = (state == BUSY) && !rst;
    assign pick = (m0_cyc_i && m1_cyc_i) ? ~last_grant : m1_cyc_i;

    assign s_cyc_o  = busy && own_cyc;
    assign s_stb_o  = busy && own_stb;
    assign s_we_o   = busy && own_we;
    assign s_addr_o = busy ? own_addr : '0;
    assign s_data_o = busy ? own_data : '0;

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = busy && s_ack_i && !owner;
    assign m1_ack_o  = busy && s_ack_i && owner;

    assign grant_o  = rst ? 2'b00 : grant_q;
    assign m0_err_o = !rst && err_q[0];
    assign m1_err_o = !rst && err_q[1];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wdog       <= '0;
            grant_q    <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            err_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (initialized_i && (m0_cyc_i || m1_cyc_i)) begin
                        owner   <= pick;
                        grant_q <= pick ? 2'b10 : 2'b01;
                        wdog    <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!own_cyc) begin
                        state      <= IDLE;
                        last_grant <= owner;
                        grant_q    <= 2'b00;
                        wdog       <= '0;
                    end else if (s_ack_i || !own_stb) begin
                        wdog <= '0;
                    end else if (wdog == WD_LAST) begin
                        err_q <= owner ? 2'b10 : 2'b01;
                        wdog  <= '0;
                        state <= DRAIN;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                DRAIN: begin
                    if (!own_cyc) begin
                        state      <= IDLE;
                        last_grant <= owner;
                        grant_q    <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Directed bench for dram_wb_arbiter.
// Small buses and an 8-cycle watchdog keep the vectors short.
module tb_dram_wb_arbiter;

    localparam int WS = 64;
    localparam int AW = 32;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          initialized_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [WS-1:0] m0_data_i, m0_data_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [WS-1:0] m1_data_i, m1_data_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [WS-1:0] s_data_o, s_data_i;
    logic          s_ack_i;
    logic [1:0]    grant_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] beat_addr [3] = '{32'h80, 32'h100, 32'h180};

    dram_wb_arbiter #(
        .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .initialized_i(initialized_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        initialized_i = 1'b0;
        {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b000;
        {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b000;
        m0_addr_i = '0; m0_data_i = '0;
        m1_addr_i = '0; m1_data_i = '0;
        s_data_i = '0; s_ack_i = 1'b0;
        step();
        step();
        chk("rst_grant", 64'(grant_o), 64'(2'b00));
        chk("rst_scyc", 64'(s_cyc_o), 64'(1'b0));
        chk("rst_sstb", 64'(s_stb_o), 64'(1'b0));
        chk("rst_ack0", 64'(m0_ack_o), 64'(1'b0));
        chk("rst_err0", 64'(m0_err_o), 64'(1'b0));
        chk("rst_err1", 64'(m1_err_o), 64'(1'b0));
        rst = 1'b0;

        // Not initialized: no grant for 20 cycles
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h40;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("noinit_scyc", 64'(s_cyc_o), 64'(1'b0));
            chk("noinit_grant", 64'(grant_o), 64'(2'b00));
        end
        initialized_i = 1'b1;
        step();
        chk("init_scyc", 64'(s_cyc_o), 64'(1'b1));
        chk("init_grant", 64'(grant_o), 64'(2'b01));
        chk("init_addr", 64'(s_addr_o), 64'(32'h40));
        s_ack_i = 1'b1; s_data_i = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("init_ack0", 64'(m0_ack_o), 64'(1'b1));
        chk("init_ack1", 64'(m1_ack_o), 64'(1'b0));
        chk("init_rdata0", m0_data_o, 64'hDEAD_BEEF_0123_4567);
        chk("init_rdata1", m1_data_o, 64'hDEAD_BEEF_0123_4567);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        chk("init_done", 64'(grant_o), 64'(2'b00));

        // Tie after reset, then alternation
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        chk("tie1_grant", 64'(grant_o), 64'(2'b01));
        s_ack_i = 1'b1;
        #1;
        chk("tie1_ack0", 64'(m0_ack_o), 64'(1'b1));
        chk("tie1_ack1", 64'(m1_ack_o), 64'(1'b0));
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        chk("tie1_idle", 64'(grant_o), 64'(2'b00));
        step();
        chk("tie1_m1", 64'(grant_o), 64'(2'b10));
        m1_cyc_i = 1'b0;
        step();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        step();
        chk("tie2_grant", 64'(grant_o), 64'(2'b01));
        m0_cyc_i = 1'b0;
        step();
        chk("tie2_idle", 64'(grant_o), 64'(2'b00));
        m0_cyc_i = 1'b1;
        step();
        chk("tie3_grant", 64'(grant_o), 64'(2'b10));
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        step();

        // Burst hold: m1 owns three write beats while m0 waits
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
        step();
        chk("burst_grant", 64'(grant_o), 64'(2'b10));
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m1_addr_i = beat_addr[i];
            m1_data_i = 64'h1111_0000 + 64'(i);
            s_ack_i = 1'b1;
            #1;
            chk("burst_addr", 64'(s_addr_o), 64'(beat_addr[i]));
            chk("burst_wdata", s_data_o, 64'h1111_0000 + 64'(i));
            chk("burst_we", 64'(s_we_o), 64'(1'b1));
            chk("burst_ack1", 64'(m1_ack_o), 64'(1'b1));
            chk("burst_ack0", 64'(m0_ack_o), 64'(1'b0));
            chk("burst_hold", 64'(grant_o), 64'(2'b10));
            step();
        end
        s_ack_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        step();
        chk("burst_idle", 64'(grant_o), 64'(2'b00));
        chk("burst_noack0", 64'(m0_ack_o), 64'(1'b0));
        step();
        chk("burst_m0", 64'(grant_o), 64'(2'b01));
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();

        // Watchdog timeout on master 0
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        chk("to_grant", 64'(grant_o), 64'(2'b01));
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_noerr", 64'(m0_err_o), 64'(1'b0));
            chk("to_stb", 64'(s_stb_o), 64'(1'b1));
        end
        step();
        chk("to_err0", 64'(m0_err_o), 64'(1'b1));
        chk("to_err1", 64'(m1_err_o), 64'(1'b0));
        chk("to_drain_stb", 64'(s_stb_o), 64'(1'b0));
        chk("to_drain_cyc", 64'(s_cyc_o), 64'(1'b0));
        chk("to_drain_grant", 64'(grant_o), 64'(2'b01));
        step();
        chk("to_err_pulse", 64'(m0_err_o), 64'(1'b0));
        chk("to_drain_hold", 64'(grant_o), 64'(2'b01));
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        chk("to_idle", 64'(grant_o), 64'(2'b00));

        // Ack lands on the timeout cycle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        for (int i = 1; i < 8; i++) step();
        s_ack_i = 1'b1;
        #1;
        chk("ackto_ack", 64'(m0_ack_o), 64'(1'b1));
        step();
        s_ack_i = 1'b0;
        #1;
        chk("ackto_noerr", 64'(m0_err_o), 64'(1'b0));
        chk("ackto_busy", 64'(s_stb_o), 64'(1'b1));
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();

        // Reset mid-read with a simultaneous ack
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        chk("rmid_busy", 64'(s_cyc_o), 64'(1'b1));
        rst = 1'b1; s_ack_i = 1'b1;
        #1;
        chk("rmid_noack", 64'(m0_ack_o), 64'(1'b0));
        step();
        rst = 1'b0;
        #1;
        chk("rmid_ack", 64'(m0_ack_o), 64'(1'b0));
        chk("rmid_scyc", 64'(s_cyc_o), 64'(1'b0));
        chk("rmid_grant", 64'(grant_o), 64'(2'b00));
        chk("rmid_err", 64'(m0_err_o), 64'(1'b0));
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_wb_arbiter.md
DRAM_WB_ARBITER -- requirements
Module: dram_wb_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 256, meaning data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning Wishbone byte address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles to wait for slave ack.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port initialized_i, input, 1 bit: DRAM calibration done; no grant while low.
REQ-007 The block SHALL have ports m0_cyc_i, m0_stb_i and m0_we_i, inputs, 1 bit each: master 0 Wishbone controls.
REQ-008 The block SHALL have ports m0_addr_i (ADDR_WIDTH bits) and m0_data_i (WORD_SIZE bits), inputs: master 0 address and write data.
REQ-009 The block SHALL have ports m0_data_o (WORD_SIZE bits), m0_ack_o (1 bit) and m0_err_o (1 bit), outputs: master 0 read data, ack and timeout error.
REQ-010 The block SHALL have ports m1_* identical to m0_* (REQ-007 to REQ-009) for master 1.
REQ-011 The block SHALL have ports s_cyc_o, s_stb_o and s_we_o (1 bit each), s_addr_o (ADDR_WIDTH bits) and s_data_o (WORD_SIZE bits), outputs: the shared DRAM wrapper port.
REQ-012 The block SHALL have ports s_data_i (WORD_SIZE bits) and s_ack_i (1 bit), inputs: wrapper read data and ack.
REQ-013 The block SHALL have port grant_o, output, 2 bits, one-hot: current owner; 00 means none.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY and DRAIN, plus a 1-bit owner register and a 1-bit last_grant register.
REQ-015 In IDLE, when initialized_i=1 and any mX_cyc_i=1, the block SHALL register a grant and enter BUSY on the next edge.
REQ-016 When both masters request, the block SHALL grant the master that is not last_grant (round-robin); a single requester SHALL be granted regardless of last_grant.
REQ-017 In BUSY, the block SHALL drive s_cyc_o, s_stb_o, s_we_o, s_addr_o and s_data_o combinationally from the owner's inputs; in IDLE and DRAIN, s_cyc_o and s_stb_o SHALL be 0.
REQ-018 The block SHALL drive owner ack as s_ack_i AND BUSY AND owner match (combinational); the non-owner's ack SHALL be 0.
REQ-019 Both mX_data_o SHALL equal s_data_i at all times, and only the ack qualifies the data.
REQ-020 The owner SHALL keep the grant for multiple stb/ack beats while its cyc stays high; a grant SHALL never be preempted.
REQ-021 In BUSY, when the owner's cyc drops, the block SHALL enter IDLE, set last_grant to owner and clear grant_o on the next edge.
REQ-022 A 16-bit watchdog SHALL clear on entry to BUSY, on every s_ack_i and whenever the owner's stb is 0, and SHALL otherwise increment in BUSY.
REQ-023 When the watchdog reaches TIMEOUT_CYCLES-1 without ack, the block SHALL pulse the owner's err_o for exactly 1 cycle and enter DRAIN.
REQ-024 If ack and timeout occur in the same cycle, the ack SHALL win: no err and no DRAIN.
REQ-025 DRAIN SHALL hold the grant with the slave idle until the owner drops cyc, then enter IDLE and update last_grant.
REQ-026 Once granted, a drop of initialized_i SHALL NOT abort the transaction; it SHALL only block new grants.
REQ-027 Minimum arbitration latency SHALL be 1 cycle from mX_cyc_i to s_cyc_o, and at least 1 IDLE cycle SHALL separate consecutive grants.

Reset
REQ-028 While rst=1, the block SHALL set state=IDLE, owner=0, last_grant=1 (so master 0 wins the first tie), watchdog=0, grant_o=00 and all s_* and mX_ack/err outputs to 0.
REQ-029 A reset asserted mid-transaction SHALL abandon it with no ack or err, and outputs SHALL be idle on the cycle after rst is sampled high.

Verification
REQ-030 Not initialized: with initialized_i=0, raise m0_cyc/stb for 20 cycles -> s_cyc_o=0 and grant_o=00; set initialized_i=1 -> s_cyc_o=1 on the next cycle.
REQ-031 Tie after reset: raise both cyc in the same cycle -> grant_o=01; after m0 finishes, master 1 is granted (10) after 1 IDLE cycle; repeat the tie -> the grant alternates.
REQ-032 Burst hold: m1 performs 3 write beats at addresses 0x80, 0x100 and 0x180 while m0 requests -> m0 is not granted until m1 drops cyc, and m0 sees no ack.
REQ-033 Timeout: with TIMEOUT_CYCLES=8, m0 stb and no ack -> m0_err_o pulses once 8 cycles after the grant, s_stb_o=0 in DRAIN, and IDLE follows m0 dropping cyc.
REQ-034 Ack at the timeout cycle: ack on the 8th cycle -> m0_ack_o=1, m0_err_o=0 and the state stays BUSY.
REQ-035 Reset mid-read: assert rst while BUSY, and assert s_ack_i in the same cycle -> no ack is forwarded and all outputs are at reset values on the next cycle.
